// File: rtl/imuldiv_muldiv_issue_ctrl.sv
// Issue controller: accepts one M-extension op, drives the mul/div unit over val/rdy, selects the result word and hands it to writeback.
// Optional WAIT-state timeout flag is built when IMULDIV_ISSUE_TIMEOUT_EN is defined.
module imuldiv_muldiv_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_val,
  output logic        op_rdy,
  input  logic [2:0]  op_fn,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic [2:0]  muldivreq_msg_fn,
  output logic [31:0] muldivreq_msg_a,
  output logic [31:0] muldivreq_msg_b,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  input  logic [63:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;

  logic [1:0] state;
  logic       sel_hi;

  assign op_rdy         = (state == IDLE);
  assign muldivreq_val  = (state == REQ);
  assign muldivresp_rdy = (state == WAIT);
  assign wb_val         = (state == WB);
  assign busy           = (state != IDLE);

  // Low word for MUL/DIV/DIVU; high word (product high half or remainder) otherwise.
  assign sel_hi = !((muldivreq_msg_fn == FN_MUL) ||
                    (muldivreq_msg_fn == FN_DIV) ||
                    (muldivreq_msg_fn == FN_DIVU));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      muldivreq_msg_fn <= '0;
      muldivreq_msg_a  <= '0;
      muldivreq_msg_b  <= '0;
      wb_rd            <= '0;
      wb_data          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_val) begin
            muldivreq_msg_fn <= op_fn;
            muldivreq_msg_a  <= op_a;
            muldivreq_msg_b  <= op_b;
            wb_rd            <= op_rd;
            state            <= REQ;
          end
        end
        REQ: begin
          if (muldivreq_rdy) state <= WAIT;
        end
        WAIT: begin
          if (muldivresp_val) begin
            wb_data <= sel_hi ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0];
            state   <= WB;
          end
        end
        WB: begin
          if (wb_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMULDIV_ISSUE_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == IDLE) && op_val) timeout_err <= 1'b0;
      if ((state == REQ) && muldivreq_rdy) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
        // Flag as the counter reaches the limit; the op itself continues untouched.
        if (({16'd0, wait_cnt} + 32'd1) >= TIMEOUT_CYCLES) timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

endmodule

// File: tb/tb_imuldiv_muldiv_issue_ctrl.sv
// Directed self-checking bench for imuldiv_muldiv_issue_ctrl; the bench plays the mul/div unit and the writeback sink.
module tb_imuldiv_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_val;
  logic        op_rdy;
  logic [2:0]  op_fn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic        wb_val;
  logic        wb_rdy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imuldiv_muldiv_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .op_val                (op_val),
    .op_rdy                (op_rdy),
    .op_fn                 (op_fn),
    .op_a                  (op_a),
    .op_b                  (op_b),
    .op_rd                 (op_rd),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .wb_rd                 (wb_rd),
    .wb_data               (wb_data),
    .busy                  (busy),
    .timeout_err           (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full op with unit and sink ready; lat = response latency in cycles after WAIT entry.
  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [63:0] res,
                        input int unsigned lat, input logic [31:0] exp);
    op_val = 1'b1; op_fn = fn; op_a = a; op_b = b; op_rd = rd;
    muldivreq_rdy = 1'b1; wb_rdy = 1'b1;
    step();
    check({tag, " req_val"}, muldivreq_val, 1);
    check({tag, " op_rdy busy"}, op_rdy, 0);
    check({tag, " req_fn"}, muldivreq_msg_fn, fn);
    check({tag, " req_a"}, muldivreq_msg_a, a);
    check({tag, " req_b"}, muldivreq_msg_b, b);
    op_val = 1'b0;
    step();
    check({tag, " resp_rdy"}, muldivresp_rdy, 1);
    check({tag, " req_val dropped"}, muldivreq_val, 0);
    for (int unsigned i = 1; i < lat; i++) begin
      step();
      check({tag, " wb_val early"}, wb_val, 0);
      check({tag, " resp_rdy hold"}, muldivresp_rdy, 1);
    end
    muldivresp_val = 1'b1; muldivresp_msg_result = res;
    step();
    check({tag, " wb_val"}, wb_val, 1);
    check({tag, " wb_data"}, wb_data, exp);
    check({tag, " wb_rd"}, wb_rd, rd);
    check({tag, " timeout_err"}, timeout_err, 0);
    muldivresp_val = 1'b0;
    step();
    check({tag, " wb_val after hs"}, wb_val, 0);
    check({tag, " op_rdy after hs"}, op_rdy, 1);
  endtask

  initial begin
    reset = 1'b0;
    op_val = 1'b0; op_fn = '0; op_a = '0; op_b = '0; op_rd = '0;
    muldivreq_rdy = 1'b0; muldivresp_val = 1'b0; muldivresp_msg_result = '0; wb_rdy = 1'b0;
    #2;
    check("rst op_rdy", op_rdy, 1);
    check("rst busy", busy, 0);
    check("rst req_val", muldivreq_val, 0);
    check("rst resp_rdy", muldivresp_rdy, 0);
    check("rst wb_val", wb_val, 0);
    check("rst wb_data", wb_data, 0);
    check("rst wb_rd", wb_rd, 0);
    check("rst req_a", muldivreq_msg_a, 0);
    check("rst timeout_err", timeout_err, 0);
    step();
    reset = 1'b1;
    step();

    run_op("mul",   3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 5'd5,  64'hFFFF_FFFF_FFFF_FFFA, 1, 32'hFFFF_FFFA);
    run_op("mulhu", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 64'hFFFF_FFFE_0000_0001, 1, 32'hFFFF_FFFE);
    run_op("rem",   3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  64'hFFFF_FFFF_FFFF_FFFD, 3, 32'hFFFF_FFFF);
    run_op("div",   3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 5'd1,  64'hFFFF_FFFF_FFFF_FFFD, 2, 32'hFFFF_FFFD);

    // Request backpressure, stray response outside WAIT, new op_val while busy, wb backpressure.
    op_val = 1'b1; op_fn = 3'd5; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; op_rd = 5'd17;
    muldivreq_rdy = 1'b0;
    step();
    op_fn = 3'd1; op_a = 32'h0; op_b = 32'h0; op_rd = 5'd2;
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      check("bp req_val", muldivreq_val, 1);
      check("bp req_fn", muldivreq_msg_fn, 3'd5);
      check("bp req_a", muldivreq_msg_a, 32'h1234_5678);
      check("bp req_b", muldivreq_msg_b, 32'h9ABC_DEF0);
      check("bp op_rdy", op_rdy, 0);
      check("bp resp_rdy", muldivresp_rdy, 0);
      step();
    end
    check("bp req_val end", muldivreq_val, 1);
    check("bp stray resp ignored", wb_data, 32'hFFFF_FFFD);
    op_val = 1'b0; muldivresp_val = 1'b0; muldivreq_rdy = 1'b1;
    step();
    check("bp wait", muldivresp_rdy, 1);
    check("bp wait no capture", wb_data, 32'hFFFF_FFFD);
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'hAAAA_5555_0F0F_0F0F; wb_rdy = 1'b0;
    step();
    muldivresp_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wbp wb_val", wb_val, 1);
      check("wbp wb_data", wb_data, 32'hAAAA_5555);
      check("wbp wb_rd", wb_rd, 17);
      check("wbp op_rdy", op_rdy, 0);
      step();
    end
    check("wbp wb_val end", wb_val, 1);
    wb_rdy = 1'b1;
    step();
    check("wbp op_rdy after hs", op_rdy, 1);
    check("wbp wb_val after hs", wb_val, 0);

    // Asynchronous reset while waiting for the response.
    op_val = 1'b1; op_fn = 3'd0; op_a = 32'h55; op_b = 32'h66; op_rd = 5'd3;
    step();
    op_val = 1'b0;
    step();
    check("arst pre wait", muldivresp_rdy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst op_rdy", op_rdy, 1);
    check("arst wb_val", wb_val, 0);
    check("arst req_val", muldivreq_val, 0);
    check("arst resp_rdy", muldivresp_rdy, 0);
    check("arst req_a", muldivreq_msg_a, 0);
    check("arst wb_data", wb_data, 0);
    step();
    reset = 1'b1;
    step();
    run_op("mulhsu", 3'd6, 32'h8000_0000, 32'h0000_0002, 5'd12, 64'hFFFF_FFFF_0000_0000, 1, 32'hFFFF_FFFF);
    run_op("divu",   3'd2, 32'h0000_0064, 32'h0000_0007, 5'd4,  64'h0000_0002_0000_000E, 1, 32'h0000_000E);

`ifdef IMULDIV_ISSUE_TIMEOUT_EN
    op_val = 1'b1; op_fn = 3'd4; op_a = 32'd10; op_b = 32'd3; op_rd = 5'd8;
    step();
    op_val = 1'b0;
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      check("to early", timeout_err, 0);
    end
    step();
    check("to set", timeout_err, 1);
    step();
    muldivresp_val = 1'b1; muldivresp_msg_result = 64'h0000_0001_0000_0003;
    step();
    muldivresp_val = 1'b0;
    check("to wb_data", wb_data, 32'h0000_0001);
    check("to sticky", timeout_err, 1);
    step();
    op_val = 1'b1; op_fn = 3'd0;
    step();
    op_val = 1'b0;
    check("to cleared", timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
